// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_STEPS = DIV_WIDTH;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor when it fits. The trial is WIDTH+1 bits so a divisor
// magnitude of 2^(WIDTH-1) (or any unsigned divisor) compares correctly.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // A borrow out of the WIDTH+1 subtraction means the divisor did not fit.
  always_comb begin
    trial    = {rem, dvd_msb};
    diff     = trial - {1'b0, dvs};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider (MIPS div), one quotient bit per clock.
// Optional macro DIV_UNSIGNED_EN adds the 'uns' input for divu behaviour.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// CALC  | one restoring step per edge, results written on the last step
// DONE  | stop (and div_zero) pulse for one cycle, then back to IDLE
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
`ifdef DIV_UNSIGNED_EN
  input  logic             uns,
`endif
  output logic             stop,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] dvd, dvs, rem;
  logic             sign_q, sign_r;
  logic             signed_op;
  logic             b_zero, last_step;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] rem_next, q_final;
  logic             q_bit;

`ifdef DIV_UNSIGNED_EN
  assign signed_op = ~uns;
`else
  assign signed_op = 1'b1;
`endif

  assign b_zero    = (b == '0);
  assign last_step = (count == CNT_W'(WIDTH - 1));
  assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;
  assign q_final   = {dvd[WIDTH-2:0], q_bit};

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[WIDTH-1]),
    .dvs      (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; a zero divisor skips straight to the done pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = b_zero ? DONE : CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and sign-corrected result write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      stop     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      stop     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (b_zero) begin
              stop     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              dvd    <= abs_a;
              dvs    <= abs_b;
              rem    <= '0;
              sign_q <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
              sign_r <= signed_op & a[WIDTH-1];
              count  <= '0;
            end
          end
        end
        CALC: begin
          rem   <= rem_next;
          dvd   <= q_final;
          count <= count + 1'b1;
          if (last_step) begin
            lo   <= sign_q ? -q_final : q_final;
            hi   <= sign_r ? -rem_next : rem_next;
            stop <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit with hand-computed quotients/remainders.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic [31:0] a, b;
  logic        start;
  logic        uns;
  logic        stop, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .start    (start),
`ifdef DIV_UNSIGNED_EN
    .uns      (uns),
`endif
    .stop     (stop),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge (edge k); return the number of edges after k at
  // which stop was first seen, or -1 if it never came within the budget.
  task automatic run_div(input logic [31:0] da, input logic [31:0] db,
                         input logic du, output int lat);
    @(negedge clk);
    a = da; b = db; uns = du; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (stop) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_div(input string tag, input logic [31:0] da, input logic [31:0] db,
                        input logic du, input logic [31:0] exp_lo,
                        input logic [31:0] exp_hi, input logic exp_dz, input int exp_lat);
    int lat;
    run_div(da, db, du, lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " lo"}, lo, exp_lo);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
    @(posedge clk); #1;
    check({tag, " stop one cycle"}, {31'd0, stop}, 32'd0);
    check({tag, " div_zero one cycle"}, {31'd0, div_zero}, 32'd0);
  endtask

  initial begin
    int lat, seen, first, second;
    reset = 1'b0; a = '0; b = '0; start = 1'b0; uns = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset stop", {31'd0, stop}, 32'd0);
    check("reset div_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clk) reset = 1'b1;

    do_div("7/2",   32'd7,        32'd2,        1'b0, 32'd3,        32'd1,        1'b0, 32);
    do_div("5/0",   32'd5,        32'd0,        1'b0, 32'd3,        32'd1,        1'b1, 0);
    do_div("-7/2",  32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 32);
    do_div("7/-2",  32'd7,        32'hFFFFFFFE, 1'b0, 32'hFFFFFFFD, 32'd1,        1'b0, 32);
    do_div("ovf",   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 32'd0,        1'b0, 32);
    do_div("min/1", 32'h80000000, 32'd1,        1'b0, 32'h80000000, 32'd0,        1'b0, 32);
    do_div("-1/2",  32'hFFFFFFFF, 32'd2,        1'b0, 32'd0,        32'hFFFFFFFF, 1'b0, 32);
`ifdef DIV_UNSIGNED_EN
    do_div("u -1/2", 32'hFFFFFFFF, 32'd2,       1'b1, 32'h7FFFFFFF, 32'd1,        1'b0, 32);
`endif

    // Reset in the middle of a division discards it.
    @(negedge clk);
    a = 32'd100; b = 32'd7; uns = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid reset hi", hi, 32'd0);
    check("mid reset lo", lo, 32'd0);
    check("mid reset stop", {31'd0, stop}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (stop) seen++;
    end
    check("no stop after reset", 32'(seen), 32'd0);
    do_div("100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 32);

    // Start re-pulsed during CALC is ignored; hi/lo hold while calculating.
    @(negedge clk);
    a = 32'd20; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    a = 32'd1000; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("calc lo stable", lo, 32'd14);
    check("calc hi stable", hi, 32'd2);
    lat = -1;
    for (int i = 6; i <= 40; i++) begin
      @(posedge clk); #1;
      if (stop) begin
        lat = i;
        break;
      end
    end
    check("repulse latency", 32'(lat), 32'd32);
    check("repulse lo", lo, 32'd6);
    check("repulse hi", hi, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    check("repulse no second stop", {31'd0, stop}, 32'd0);

    // Start held high: the next division is accepted on the first IDLE edge.
    @(negedge clk);
    a = 32'd7; b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    first = -1; second = -1;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      if (stop) begin
        if (first < 0) first = i;
        else begin
          second = i;
          break;
        end
      end
    end
    start = 1'b0;
    check("held start first", 32'(first), 32'd32);
    check("held start second", 32'(second), 32'd66);
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
